// File: rtl/conv_weight_streamer_pkg.sv
// Shared definitions for the conv-layer weight streamer.
// Holds the weight array geometry, the FSM state encoding and the byte-lane
// positions inside the 16-bit streamed word.
package conv_weight_streamer_pkg;

  localparam int CWS_NUM_KERNEL  = 32;
  localparam int CWS_TAPS        = 77;
  localparam int CWS_TOTAL_WORDS = CWS_NUM_KERNEL * CWS_TAPS;

  // data_out lanes: weight in the low byte, kernel tag (or zero) in the high byte
  localparam int WEIGHT_LANE_LSB = 0;
  localparam int WEIGHT_LANE_MSB = 7;
  localparam int TAG_LANE_LSB    = 8;
  localparam int TAG_LANE_MSB    = 15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_DRAIN = 2'b10,
    ST_DONE  = 2'b11
  } cws_state_e;

endpackage

// File: rtl/conv_weight_streamer_if.sv
// Valid/ready stream from the weight streamer into the weight buffer's
// serial input.
//   data_out   : streamed word
//   data_valid : data_out holds a word
//   data_ready : sink accepts; transfer when valid & ready at a rising edge
interface conv_weight_streamer_if #(
  parameter int OUT_W = 16
);
  logic [OUT_W-1:0] data_out;
  logic             data_valid;
  logic             data_ready;

  modport master (output data_out, output data_valid, input data_ready);
  modport slave  (input data_out, input data_valid, output data_ready);
endinterface

// File: rtl/conv_weight_streamer_weight_skid_fifo.sv
// weight_skid_fifo: 2-entry FIFO sitting between the ROM read port and the
// output stream. Absorbs the one-cycle ROM latency under backpressure.
//   push/push_data : write an entry (accepted when not full, or when popping)
//   pop            : remove head (ignored when empty)
//   head           : oldest entry, stable until popped
//   empty/full     : occupancy flags
//   count          : occupancy 0..2
module weight_skid_fifo #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         empty,
  output logic         full,
  output logic [1:0]   count
);

  logic [W-1:0] mem_q [2];
  logic         wr_q;
  logic         rd_q;
  logic [1:0]   count_q;
  logic         pop_ok;
  logic         push_ok;

  assign pop_ok  = pop & (count_q != 2'd0);
  // a push into a full FIFO is fine when the head leaves on the same edge
  assign push_ok = push & ((count_q != 2'd2) | pop_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      count_q <= 2'd0;
    end else begin
      if (push_ok) begin
        mem_q[wr_q] <= push_data;
        wr_q        <= ~wr_q;
      end
      if (pop_ok) rd_q <= ~rd_q;
      count_q <= count_q + {1'b0, push_ok} - {1'b0, pop_ok};
    end
  end

  assign head  = mem_q[rd_q];
  assign empty = (count_q == 2'd0);
  assign full  = (count_q == 2'd2);
  assign count = count_q;

endmodule

// File: rtl/conv_weight_streamer.sv
// conv_weight_streamer: reads NUM_KERNEL x TAPS int8 weights from a
// 1-cycle-latency ROM in kernel-major, tap-minor order and streams them one
// word per cycle over a valid/ready interface, weight in the low byte.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : one-cycle pulse, begins a load (ignored while busy)
//   rom_en     : ROM read enable
//   rom_addr   : ROM address, kernel*TAPS+tap
//   rom_data   : ROM data, valid the cycle after rom_en
//   strm       : output stream (master modport)
//   busy       : loading (RUN or DRAIN)
//   done       : load complete, held until the next start
// Optional macro WEIGHT_STREAM_TAG_EN: data_out[15:8] carries the kernel
// index of each word; otherwise the high byte is zero.
module conv_weight_streamer
  import conv_weight_streamer_pkg::*;
#(
  parameter int NUM_KERNEL = CWS_NUM_KERNEL,
  parameter int TAPS       = CWS_TAPS,
  parameter int DW         = 8,
  parameter int OUT_W      = 16,
  parameter int ADDR_W     = 12
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output logic                   rom_en,
  output logic [ADDR_W-1:0]      rom_addr,
  input  logic [DW-1:0]          rom_data,
  conv_weight_streamer_if.master strm,
  output logic                   busy,
  output logic                   done
);

  localparam int TOTAL = NUM_KERNEL * TAPS;
  localparam int KW    = $clog2(NUM_KERNEL);
  localparam int TW    = $clog2(TAPS);
`ifdef WEIGHT_STREAM_TAG_EN
  localparam int EW    = DW + KW;
`else
  localparam int EW    = DW;
`endif

  cws_state_e        state_q;
  logic [ADDR_W-1:0] addr_q;
  logic              inflight_q;
  logic [KW-1:0]     kern_q;
  logic [TW-1:0]     tap_q;
`ifdef WEIGHT_STREAM_TAG_EN
  logic [KW-1:0]     pkern_q;
  logic [TW-1:0]     ptap_q;
`endif

  logic          push;
  logic          pop;
  logic [EW-1:0] push_data;
  logic [EW-1:0] head;
  logic          fifo_empty;
  logic          fifo_full;
  logic [1:0]    fifo_count;
  logic [2:0]    occ_d;
  logic          last_issue;
  logic          last_xfer;

  assign pop  = strm.data_valid & strm.data_ready;
  assign push = inflight_q;

  // Occupancy after this edge if nothing new were issued. Issuing only while
  // this is below 2 means every returning ROM word has a FIFO slot.
  assign occ_d      = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
  assign rom_en     = (state_q == ST_RUN) && (occ_d < 3'd2);
  assign rom_addr   = addr_q;
  assign last_issue = (addr_q == ADDR_W'(TOTAL - 1));
  assign last_xfer  = pop && (kern_q == KW'(NUM_KERNEL - 1)) && (tap_q == TW'(TAPS - 1));

  assign busy = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done = (state_q == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      inflight_q <= 1'b0;
      kern_q     <= '0;
      tap_q      <= '0;
`ifdef WEIGHT_STREAM_TAG_EN
      pkern_q    <= '0;
      ptap_q     <= '0;
`endif
    end else begin
      inflight_q <= rom_en;

      if (pop) begin
        if (tap_q == TW'(TAPS - 1)) begin
          tap_q  <= '0;
          kern_q <= (kern_q == KW'(NUM_KERNEL - 1)) ? '0 : kern_q + KW'(1);
        end else begin
          tap_q <= tap_q + TW'(1);
        end
      end

`ifdef WEIGHT_STREAM_TAG_EN
      // push-side position, so each FIFO entry carries its own kernel index
      if (push) begin
        if (ptap_q == TW'(TAPS - 1)) begin
          ptap_q  <= '0;
          pkern_q <= (pkern_q == KW'(NUM_KERNEL - 1)) ? '0 : pkern_q + KW'(1);
        end else begin
          ptap_q <= ptap_q + TW'(1);
        end
      end
`endif

      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q <= ST_RUN;
            addr_q  <= '0;
            kern_q  <= '0;
            tap_q   <= '0;
`ifdef WEIGHT_STREAM_TAG_EN
            pkern_q <= '0;
            ptap_q  <= '0;
`endif
          end
        end
        ST_RUN: begin
          if (rom_en) begin
            if (last_issue) state_q <= ST_DRAIN;
            else            addr_q  <= addr_q + ADDR_W'(1);
          end
        end
        ST_DRAIN: begin
          // final word leaving with nothing queued behind it
          if (last_xfer && !fifo_full && !inflight_q) state_q <= ST_DONE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef WEIGHT_STREAM_TAG_EN
  assign push_data = {pkern_q, rom_data};
  assign strm.data_out[TAG_LANE_MSB:TAG_LANE_LSB] = 8'(head[EW-1:DW]);
`else
  assign push_data = rom_data;
  assign strm.data_out[TAG_LANE_MSB:TAG_LANE_LSB] = '0;
`endif
  assign strm.data_out[WEIGHT_LANE_MSB:WEIGHT_LANE_LSB] = head[DW-1:0];
  assign strm.data_valid = ~fifo_empty;

  weight_skid_fifo #(
    .W (EW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_conv_weight_streamer.sv
// Directed bench for conv_weight_streamer: ROM model with ROM[n]=n[7:0],
// negedge monitor capturing transfers, one task per scenario.
module tb_conv_weight_streamer;

  localparam int NK    = 32;
  localparam int TP    = 77;
  localparam int TOTAL = NK * TP;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        rom_en;
  logic [11:0] rom_addr;
  logic [7:0]  rom_data = 8'h00;
  logic        busy;
  logic        done;

  conv_weight_streamer_if #(.OUT_W(16)) strm_if ();

  conv_weight_streamer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .rom_en   (rom_en),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .strm     (strm_if.master),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ROM model: one-cycle latency
  always @(posedge clk) if (rom_en) rom_data <= rom_addr[7:0];

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // monitor state
  logic [15:0] cap[$];
  logic [15:0] ref_cap[$];
  int   first_cyc, last_cyc, done_cyc;
  bit   done_seen;
  int   issued, accepted, max_out;
  int   stab_viol, credit_viol;
  bit   prev_hold;
  logic [15:0] prev_data;
  bit   mon_pop;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      mon_pop = strm_if.data_valid && strm_if.data_ready;
      if (rom_en && ((issued - accepted - (mon_pop ? 1 : 0)) >= 2)) credit_viol++;
      if (prev_hold && (!strm_if.data_valid || strm_if.data_out !== prev_data)) stab_viol++;
      prev_hold = strm_if.data_valid && !strm_if.data_ready;
      prev_data = strm_if.data_out;
      if (mon_pop) begin
        if (cap.size() == 0) first_cyc = cyc;
        cap.push_back(strm_if.data_out);
        last_cyc = cyc;
        accepted++;
      end
      if (rom_en) issued++;
      if ((issued - accepted) > max_out) max_out = issued - accepted;
      if (done && !done_seen) begin
        done_seen = 1'b1;
        done_cyc  = cyc;
      end
    end
  end

  task automatic mon_clear();
    cap.delete();
    first_cyc = -1; last_cyc = -1; done_cyc = -1; done_seen = 1'b0;
    issued = 0; accepted = 0; max_out = 0;
    stab_viol = 0; credit_viol = 0; prev_hold = 1'b0;
  endtask

  function automatic logic [15:0] exp_word(input int n);
    logic [7:0] hi;
`ifdef WEIGHT_STREAM_TAG_EN
    hi = 8'(n / TP);
`else
    hi = 8'h00;
`endif
    return {hi, 8'(n % 256)};
  endfunction

  // pulse start across one edge; returns cycle index seen after that edge
  task automatic pulse_start(output int s);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    s = cyc;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (done) begin ok = 1'b1; break; end
    end
    @(negedge clk); #1;
  endtask

  task automatic check_stream(input string tag);
    int bad = 0;
    int first_bad = -1;
    logic [15:0] got_bad = 16'h0;
    checks++;
    if (cap.size() !== TOTAL) begin
      errors++;
      $display("FAIL %s_count: got %0d words, expected %0d", tag, cap.size(), TOTAL);
    end
    for (int n = 0; n < cap.size() && n < TOTAL; n++) begin
      if (cap[n] !== exp_word(n)) begin
        if (first_bad < 0) begin first_bad = n; got_bad = cap[n]; end
        bad++;
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s_order: %0d bad words, first at %0d got %h expected %h",
               tag, bad, first_bad, got_bad, exp_word(first_bad));
    end
  endtask

  task automatic test_reset();
    strm_if.data_ready = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    checks++;
    if ({rom_en, rom_addr, strm_if.data_valid, strm_if.data_out, busy, done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: en=%b addr=%h vld=%b data=%h busy=%b done=%b, expected all 0",
               rom_en, rom_addr, strm_if.data_valid, strm_if.data_out, busy, done);
    end
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({rom_en, busy, done, strm_if.data_valid} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_idle: en=%b busy=%b done=%b vld=%b, expected 0000",
               rom_en, busy, done, strm_if.data_valid);
    end
  endtask

  task automatic test_full_rate();
    int s;
    bit ok;
    mon_clear();
    strm_if.data_ready = 1'b1;
    pulse_start(s);
    checks++;
    if (rom_en !== 1'b1 || busy !== 1'b1 || strm_if.data_valid !== 1'b0) begin
      errors++;
      $display("FAIL fr_first_issue: en=%b busy=%b vld=%b, expected 1 1 0", rom_en, busy, strm_if.data_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (strm_if.data_valid !== 1'b0) begin
      errors++;
      $display("FAIL fr_valid_e1: got %b expected 0", strm_if.data_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (strm_if.data_valid !== 1'b1 || strm_if.data_out !== 16'h0000) begin
      errors++;
      $display("FAIL fr_valid_e2: vld=%b data=%h expected 1 0000", strm_if.data_valid, strm_if.data_out);
    end
    wait_done(3000, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL fr_done_timeout: done=%b expected 1 within budget", done);
    end
    check_stream("fr");
    checks++;
    if (first_cyc !== s + 2 || last_cyc !== s + TOTAL + 1) begin
      errors++;
      $display("FAIL fr_timing: first=%0d last=%0d expected %0d %0d",
               first_cyc - s, last_cyc - s, 2, TOTAL + 1);
    end
    checks++;
    if (done_cyc !== last_cyc + 1) begin
      errors++;
      $display("FAIL fr_done_cycle: got %0d expected %0d", done_cyc - s, last_cyc + 1 - s);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b1 || strm_if.data_valid !== 1'b0 || rom_addr !== 12'(TOTAL - 1)) begin
      errors++;
      $display("FAIL fr_end_state: busy=%b done=%b vld=%b addr=%0d expected 0 1 0 %0d",
               busy, done, strm_if.data_valid, rom_addr, TOTAL - 1);
    end
    ref_cap = cap;
  endtask

  task automatic test_control_edges();
    int s;
    bit ok;
    int diff = 0;
    mon_clear();
    strm_if.data_ready = 1'b1;
    pulse_start(s);
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL ce_restart: done=%b busy=%b expected 0 1", done, busy);
    end
    repeat (50) @(posedge clk);
    pulse_start(s);
    repeat (500) @(posedge clk);
    pulse_start(s);
    wait_done(3000, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL ce_done_timeout: done=%b expected 1", done);
    end
    check_stream("ce");
    for (int n = 0; n < cap.size() && n < ref_cap.size(); n++)
      if (cap[n] !== ref_cap[n]) diff++;
    checks++;
    if (diff != 0 || ref_cap.size() != TOTAL) begin
      errors++;
      $display("FAIL ce_repeat: %0d words differ from first load (ref size %0d), expected 0",
               diff, ref_cap.size());
    end
  endtask

  task automatic test_backpressure();
    int s;
    bit ok = 1'b0;
    mon_clear();
    strm_if.data_ready = 1'b0;
    pulse_start(s);
    for (int i = 0; i < 20000; i++) begin
      @(posedge clk); #1;
      if (done) begin ok = 1'b1; break; end
      strm_if.data_ready = ($urandom_range(0, 9) < 3);
    end
    @(negedge clk); #1;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL bp_done_timeout: done=%b expected 1", done);
    end
    check_stream("bp");
    checks++;
    if (stab_viol != 0) begin
      errors++;
      $display("FAIL bp_stable: %0d unstable held words, expected 0", stab_viol);
    end
    checks++;
    if (credit_viol != 0 || max_out > 2) begin
      errors++;
      $display("FAIL bp_credit: %0d over-issues, max outstanding %0d, expected 0 and <=2",
               credit_viol, max_out);
    end
  endtask

  task automatic test_stall_resume();
    int s;
    bit ok = 1'b0;
    int acc0;
    mon_clear();
    strm_if.data_ready = 1'b1;
    pulse_start(s);
    for (int i = 0; i < 20; i++) begin
      if (cap.size() > 0) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL sr_first_word: got %0d words expected >0", cap.size());
    end
    strm_if.data_ready = 1'b0;
    acc0 = accepted;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if ((issued - accepted) > 2 || accepted != acc0 || strm_if.data_valid !== 1'b1 || rom_en !== 1'b0) begin
      errors++;
      $display("FAIL sr_stall: outstanding=%0d accepted %0d->%0d vld=%b en=%b expected <=2 unchanged 1 0",
               issued - accepted, acc0, accepted, strm_if.data_valid, rom_en);
    end
    strm_if.data_ready = 1'b1;
    wait_done(3000, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL sr_done_timeout: done=%b expected 1", done);
    end
    check_stream("sr");
  endtask

  task automatic test_reset_midop();
    int s;
    strm_if.data_ready = 1'b1;
    pulse_start(s);
    repeat (100) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({rom_en, rom_addr, strm_if.data_valid, strm_if.data_out, busy, done} !== '0) begin
      errors++;
      $display("FAIL midop_reset: en=%b addr=%h vld=%b data=%h busy=%b done=%b, expected all 0",
               rom_en, rom_addr, strm_if.data_valid, strm_if.data_out, busy, done);
    end
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, rom_en, strm_if.data_valid} !== 4'b0000) begin
      errors++;
      $display("FAIL midop_idle: busy=%b done=%b en=%b vld=%b expected 0000",
               busy, done, rom_en, strm_if.data_valid);
    end
  endtask

  initial begin
    strm_if.data_ready = 1'b0;
    mon_clear();
    test_reset();
    test_full_rate();
    test_control_edges();
    test_backpressure();
    test_stall_resume();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
